// File: rtl/prbs_pkg.sv
// Shared types and constants for the x^5 + x^3 + 1 PRBS checker.
package prbs_pkg;

    typedef enum logic [1:0] {
        ST_SEED,
        ST_HUNT,
        ST_LOCKED
    } state_t;

    localparam int unsigned PRBS_W   = 5;
    localparam int unsigned TAP_A    = 0;
    localparam int unsigned TAP_B    = 2;
    localparam int unsigned SEED_LEN = PRBS_W;

    // Next bit predicted from the history register (b[n+5] = b[n] ^ b[n+2]).
    function automatic logic prbs_exp(input logic [PRBS_W-1:0] h);
        return h[TAP_A] ^ h[TAP_B];
    endfunction

endpackage

// File: rtl/prbs_sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module prbs_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS5 checker: seed, hunt for lock, flywheel while locked and count errors.
// Define PRBS_CHK_BITCNT_EN to build the locked-bit counter; otherwise bit_cnt reads 0.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int unsigned LOCK_CNT    = 8,
    parameter int unsigned LOSS_THRESH = 3,
    parameter int unsigned ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             bit_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [31:0]      bit_cnt
);

    localparam int unsigned MATCH_W = 8;
    localparam int unsigned MISS_W  = 4;
    localparam int unsigned SEED_W  = 3;

    state_t              state, state_next;
    logic [PRBS_W-1:0]   h, h_next;
    logic [MATCH_W-1:0]  match_cnt, match_next;
    logic [MISS_W-1:0]   miss_cnt, miss_next;
    logic [SEED_W-1:0]   seed_cnt, seed_next;
    logic                exp_bit;
    logic                bit_err_next;
    logic                err_inc;
    logic                chk_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SEED;
            h         <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            seed_cnt  <= '0;
            locked    <= 1'b0;
            bit_err   <= 1'b0;
        end else begin
            state     <= state_next;
            h         <= h_next;
            match_cnt <= match_next;
            miss_cnt  <= miss_next;
            seed_cnt  <= seed_next;
            locked    <= (state_next == ST_LOCKED);
            bit_err   <= bit_err_next;
        end
    end

    always_comb begin
        state_next   = state;
        h_next       = h;
        match_next   = match_cnt;
        miss_next    = miss_cnt;
        seed_next    = seed_cnt;
        bit_err_next = 1'b0;
        err_inc      = 1'b0;
        chk_inc      = 1'b0;
        exp_bit      = prbs_exp(h);

        if (din_valid) begin
            case (state)
                ST_SEED: begin
                    h_next = {din, h[PRBS_W-1:1]};
                    if (seed_cnt == SEED_W'(SEED_LEN - 1)) begin
                        state_next = ST_HUNT;
                        seed_next  = '0;
                        match_next = '0;
                    end else begin
                        seed_next = seed_cnt + SEED_W'(1);
                    end
                end
                ST_HUNT: begin
                    h_next = {din, h[PRBS_W-1:1]};
                    // An all-zero history predicts zeros forever, so it never counts as a match.
                    if ((din == exp_bit) && (h != '0)) begin
                        if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                            state_next = ST_LOCKED;
                            match_next = '0;
                            miss_next  = '0;
                        end else begin
                            match_next = match_cnt + MATCH_W'(1);
                        end
                    end else begin
                        match_next = '0;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: history follows the prediction, not the possibly corrupted input.
                    h_next  = {exp_bit, h[PRBS_W-1:1]};
                    chk_inc = 1'b1;
                    if (din != exp_bit) begin
                        bit_err_next = 1'b1;
                        err_inc      = 1'b1;
                        if (miss_cnt == MISS_W'(LOSS_THRESH - 1)) begin
                            state_next = ST_HUNT;
                            match_next = '0;
                            miss_next  = '0;
                        end else begin
                            miss_next = miss_cnt + MISS_W'(1);
                        end
                    end else begin
                        miss_next = '0;
                    end
                end
                default: begin
                    state_next = ST_SEED;
                end
            endcase
        end
    end

    prbs_sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk(clk),
        .rst(rst),
        .clr(clr_cnt),
        .inc(err_inc),
        .cnt(err_cnt)
    );

`ifdef PRBS_CHK_BITCNT_EN
    prbs_sat_counter #(
        .W(32)
    ) u_bit_cnt (
        .clk(clk),
        .rst(rst),
        .clr(clr_cnt),
        .inc(chk_inc),
        .cnt(bit_cnt)
    );
`else
    logic bitcnt_unused;
    assign bitcnt_unused = chk_inc;
    assign bit_cnt       = '0;
`endif

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial PRBS checker for the 5-bit maximal-length sequence x^5 + x^3 + 1 (period 31, recurrence b[n+5] = b[n] ^ b[n+2]). It is the receive end of the team's LFSR pattern source: it seeds itself from the incoming bit stream, declares lock after a run of correct predictions, and then flywheels on its own state. While locked it counts bit errors and declares loss of lock after repeated mismatches. It sits on the loopback/test path feeding status LEDs and the debug readout.

## Interface
- LOCK_CNT, 8: consecutive correct predictions needed to enter LOCKED (1..255)
- LOSS_THRESH, 3: consecutive mismatches in LOCKED that force re-hunt (1..15)
- ERR_W, 16: width of the saturating error counter

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- din  in  1  received serial bit, generator register bit 0
- din_valid  in  1  qualifies din; state advances only on valid cycles
- clr_cnt  in  1  synchronous clear of the error counter (and the bit counter, if built)
- locked  out  1  high while in LOCKED
- bit_err  out  1  one-cycle pulse per mismatched valid bit while LOCKED
- err_cnt  out  ERR_W  saturating count of LOCKED mismatches
- bit_cnt  out  32  bits checked while LOCKED (see Configuration)

## Operation
- History register H[4:0]; expected bit exp = H[0] ^ H[2].
- SEED: each valid bit shifts H <= {din, H[4:1]}. After 5 valid bits, go to HUNT with match count 0.
- HUNT: on each valid bit, compare din with exp, then shift din into H.
  - Match with H != 0: increment match count. When the count reaches LOCK_CNT, go to LOCKED.
  - Mismatch, or H == 0: clear the match count. An all-zero stream never locks.
- LOCKED: on each valid bit, shift exp into H (flywheel), so input errors never corrupt H.
  - din != exp: pulse bit_err, increment err_cnt, increment the miss count.
  - Match: clear the miss count.
  - Miss count reaches LOSS_THRESH: go to HUNT with match count 0. err_cnt keeps its value.
- err_cnt saturates at 2^ERR_W-1.
- clr_cnt takes priority over an error in the same cycle: err_cnt becomes 0 and that error is not counted, but bit_err still pulses.
- din_valid low: no state, counter or H change; bit_err is 0.

## Timing
- All outputs are registered and update on the clock edge after the valid input cycle (latency 1).
- Reset values: state SEED, H = 0, match count 0, miss count 0, locked 0, bit_err 0, err_cnt 0, bit_cnt 0.
- rst asserted mid-operation returns the block to SEED on the next edge, regardless of din_valid.
- locked rises one cycle after valid bit number 5 + LOCK_CNT when the stream is clean from reset (bit 13 with defaults).
- locked falls one cycle after the valid bit that makes the LOSS_THRESH-th consecutive miss. bit_err pulses for that bit as well.

## Configuration
- PRBS_CHK_BITCNT_EN defined: bit_cnt counts every valid bit checked while LOCKED, saturating at 2^32-1, and is cleared by clr_cnt and rst.
- Macro undefined: the counter logic is omitted and bit_cnt is tied to 0. The port stays present so the interface does not change.

## Structure
- Package prbs_pkg holds:
  - state enum {ST_SEED, ST_HUNT, ST_LOCKED}
  - PRBS_W = 5
  - tap positions TAP_A = 0 and TAP_B = 2
  - seed length constant
- Sub-module prbs_sat_counter: parameterised width, with increment, clear (priority) and saturation. It is instantiated for err_cnt and, when PRBS_CHK_BITCNT_EN is defined, for bit_cnt.

## Test plan
- Clean lock: reset, then a continuous valid stream from a generator seeded 5'b00001 (bits 1,0,0,0,0,1,...) -> locked goes high one cycle after the 13th bit; err_cnt = 0; bit_err never pulses.
- Single-bit error: after lock, invert one bit -> exactly one bit_err pulse; err_cnt = 1; locked stays 1; no follow-on errors.
- Loss and relock: after lock, invert 3 consecutive bits -> err_cnt = 3; locked drops after the 3rd; locked returns after 8 further clean bits.
- Stuck-at-zero and gaps: din = 0 constantly for 100 valid cycles -> locked stays 0. Then a clean stream with din_valid toggling every other cycle -> lock after 13 valid bits, with no advance on invalid cycles.
- Counter edge cases: with ERR_W = 2, 5 isolated errors -> err_cnt = 3. Then clr_cnt in the same cycle as an error -> err_cnt = 0 and bit_err = 1.
- Reset mid-lock: assert rst for one cycle while locked -> the next cycle shows locked = 0, err_cnt = 0, bit_cnt = 0; relock after 13 clean bits. With PRBS_CHK_BITCNT_EN defined, bit_cnt matches the number of valid locked bits.
